// File: rtl/halflife_meter.sv
// halflife_meter: captures a reference sample and counts cycles until a sample falls to half of it
module halflife_meter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] sample,
  input  logic         sample_valid,
  output logic         busy,
  output logic         done,
  output logic         result_valid,
  output logic [W-1:0] period,
  output logic [N-1:0] ref_val,
  output logic         timeout,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
  localparam logic [W-1:0] CMAX = '1;
  state_t state, nxt;
  logic [N-1:0] thr;
  logic [W-1:0] cnt;
  logic hit, sat;
  assign hit = sample_valid && (sample <= thr);
  assign sat = cnt == CMAX;
  // state register
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // next state; start always (re)arms, aborting any run in progress
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? ARM : IDLE;
      ARM:     nxt = start ? ARM : !sample_valid ? ARM : (sample == '0) ? DONE : MEASURE;
      MEASURE: nxt = start ? ARM : (hit || sat) ? DONE : MEASURE;
      DONE:    nxt = start ? ARM : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // status outputs decoded from state
  always_comb begin
    busy = (state == ARM) || (state == MEASURE);
    done = state == DONE;
  end
  // capture, counting and result registers; a crossing takes priority over saturation
  always_ff @(posedge clk)
    if (!rst) begin
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      err          <= 1'b0;
      period       <= '0;
      ref_val      <= '0;
      thr          <= '0;
      cnt          <= '0;
    end else if (start) begin
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      err          <= 1'b0;
      period       <= '0;
      cnt          <= '0;
    end else if (state == ARM && sample_valid) begin
      ref_val <= sample;
      thr     <= sample >> 1;
      cnt     <= W'(1);
      err     <= sample == '0;
      period  <= '0;
    end else if (state == MEASURE) begin
      if (hit) begin
        period       <= cnt;
        result_valid <= 1'b1;
      end else if (sat) begin
        period  <= CMAX;
        timeout <= 1'b1;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_halflife_meter.sv
// tb_halflife_meter: directed scenarios plus random stimulus against a cycle-elapsed reference model
module tb_halflife_meter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int PMAX = (1 << W) - 1;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, sample_valid = 1'b0;
  logic [N-1:0] sample = '0;
  logic busy, done, result_valid, timeout, err;
  logic [W-1:0] period;
  logic [N-1:0] ref_val;
  int checks = 0, errors = 0;
  int ph = 0, m_rv = 0, m_to = 0, m_er = 0, m_per = 0, m_ref = 0, cap = 0, e = 0, dec = 0;

  halflife_meter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sample(sample), .sample_valid(sample_valid),
    .busy(busy), .done(done), .result_valid(result_valid), .period(period),
    .ref_val(ref_val), .timeout(timeout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ph: 0 idle, 1 waiting for reference, 2 measuring, 3 reporting
  task automatic model();
    int el;
    e++;
    if (!rst) begin
      ph = 0; m_rv = 0; m_to = 0; m_er = 0; m_per = 0; m_ref = 0;
    end else if (start) begin
      ph = 1; m_rv = 0; m_to = 0; m_er = 0; m_per = 0;
    end else if (ph == 1) begin
      if (sample_valid) begin
        m_ref = int'(sample);
        cap = e;
        if (sample == 0) begin m_er = 1; ph = 3; end
        else ph = 2;
      end
    end else if (ph == 2) begin
      el = e - cap;
      if (sample_valid && int'(sample) <= m_ref / 2) begin m_per = el; m_rv = 1; ph = 3; end
      else if (el == PMAX) begin m_per = PMAX; m_to = 1; ph = 3; end
    end else if (ph == 3) ph = 0;
  endtask

  task automatic compare_all();
    check("busy", 32'(busy), 32'(ph == 1 || ph == 2));
    check("done", 32'(done), 32'(ph == 3));
    check("result_valid", 32'(result_valid), 32'(m_rv));
    check("timeout", 32'(timeout), 32'(m_to));
    check("err", 32'(err), 32'(m_er));
    check("period", 32'(period), 32'(m_per));
    check("ref_val", 32'(ref_val), 32'(m_ref));
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    compare_all();
  endtask

  task automatic cyc(input logic st, input logic v, input logic [N-1:0] s);
    start = st; sample_valid = v; sample = s;
    step();
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); sample_valid = 1'($urandom); sample = N'($urandom);
      step();
    end
    check("rst_busy", 32'(busy), 0);
    check("rst_period", 32'(period), 0);
    check("rst_ref", 32'(ref_val), 0);
    rst = 1'b1;
    cyc(0, 0, 0);
    // nominal decay 8,7,6,5,4
    cyc(1, 0, 0);
    check("nom_busy", 32'(busy), 1);
    cyc(0, 1, 8);
    for (int s = 7; s >= 4; s--) cyc(0, 1, N'(s));
    check("nom_done", 32'(done), 1);
    check("nom_period", 32'(period), 4);
    check("nom_ref", 32'(ref_val), 8);
    check("nom_rv", 32'(result_valid), 1);
    cyc(0, 0, 0);
    check("nom_done_once", 32'(done), 0);
    check("nom_hold", 32'(period), 4);
    // gaps in sample_valid still count
    cyc(1, 0, 0);
    cyc(0, 1, 6);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(0, 1, 3);
    check("gap_period", 32'(period), 4);
    check("gap_done", 32'(done), 1);
    cyc(0, 0, 0);
    check("gap_done_once", 32'(done), 0);
    // timeout
    cyc(1, 0, 0);
    cyc(0, 1, 15);
    for (int i = 0; i < 14; i++) cyc(0, 1, 15);
    check("to_not_yet", 32'(done), 0);
    cyc(0, 1, 15);
    check("to_flag", 32'(timeout), 1);
    check("to_period", 32'(period), 15);
    check("to_rv", 32'(result_valid), 0);
    check("to_done", 32'(done), 1);
    cyc(0, 0, 0);
    // zero reference
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    check("zero_err", 32'(err), 1);
    check("zero_period", 32'(period), 0);
    check("zero_done", 32'(done), 1);
    cyc(0, 0, 0);
    check("zero_idle", 32'(busy), 0);
    // abort and restart
    cyc(1, 0, 0);
    cyc(0, 1, 10);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("abort_nodone", 32'(done), 0);
    cyc(0, 1, 4);
    cyc(0, 1, 2);
    check("abort_ref", 32'(ref_val), 4);
    check("abort_period", 32'(period), 1);
    check("abort_done", 32'(done), 1);
    // start during the done cycle re-arms
    cyc(1, 0, 0);
    check("redone_busy", 32'(busy), 1);
    cyc(0, 1, 5);
    cyc(0, 1, 2);
    check("odd_thr_period", 32'(period), 1);
    // odd reference: 5 -> threshold 2, sample 3 must not cross
    cyc(1, 0, 0);
    cyc(0, 1, 5);
    cyc(0, 1, 3);
    check("odd_no_cross", 32'(done), 0);
    cyc(0, 1, 2);
    check("odd_cross", 32'(period), 2);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 299) != 0;
      start = $urandom_range(0, 24) == 0;
      if (start) dec = $urandom_range(0, 15);
      else if ($urandom_range(0, 2) == 0 && dec > 0) dec--;
      sample_valid = $urandom_range(0, 9) < 7;
      sample = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'(dec);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
